multicycle_control: RTL and testbench

- Multi-cycle sequencer for the RISC-V core: steps each instruction through BOOT/FETCH/DECODE/EXEC/MEM/WB.
- Drives the immediate-extender type select, ALU operand muxes, PC/IR write enables, memory handshakes and register write-back.
- Sits between the instruction register/memories and the datapath (ImmExtend, ALU, register file, PC).
- Traps on illegal opcode or memory timeout.

---
 rtl/multicycle_control.sv | 239 +++++++++++++++++++++++
 tb/tb_multicycle_control.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle instruction sequencer for the RISC-V core.
// Steps each instruction through BOOT/FETCH/DECODE/EXEC/MEM/WB. It drives the
// immediate-type select, ALU operand muxes, PC/IR enables, memory handshakes
// and register write-back, and halts with a sticky trap on an illegal opcode
// or a memory that never answers.
module multicycle_control #(
    parameter int TYPE_W      = 3,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [31:0]       ins,
    input  logic              ins_ready,
    input  logic              dmem_ready,
    input  logic              br_taken,
    output logic              ins_req,
    output logic              ir_write,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic              pc_write,
    output logic              pc_src,
    output logic [TYPE_W-1:0] imm_type,
    output logic [1:0]        alu_src_a,
    output logic              alu_src_b,
    output logic [1:0]        alu_ctl,
    output logic              reg_write,
    output logic [1:0]        wb_sel,
    output logic              trap,
    output logic [1:0]        trap_cause,
    output logic [2:0]        state
);

    typedef enum logic [2:0] {
        S_BOOT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_HALT   = 3'd6
    } state_t;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [TYPE_W-1:0] IMM_I = TYPE_W'(0);
    localparam logic [TYPE_W-1:0] IMM_S = TYPE_W'(1);
    localparam logic [TYPE_W-1:0] IMM_B = TYPE_W'(2);
    localparam logic [TYPE_W-1:0] IMM_U = TYPE_W'(3);
    localparam logic [TYPE_W-1:0] IMM_J = TYPE_W'(4);

    // Wait counter only needs to count up to MEM_TIMEOUT-1.
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    state_t             cur_state;
    state_t             next_state;
    logic [CNT_W-1:0]   wait_cnt;
    logic [1:0]         trap_cause_q;
    logic [1:0]         next_cause;
    logic               timeout_hit;
    logic               waiting;

    logic               is_lui, is_auipc, is_jal, is_jalr, is_branch;
    logic               is_load, is_store, is_opimm, is_op, is_legal;
    logic [TYPE_W-1:0]  dec_imm;

    // Only the opcode field matters for sequencing; the rest of INS is ignored.
    logic unused_ins_bits;
    assign unused_ins_bits = ^ins[31:7];

    // The count hitting the limit on a not-ready cycle is the last allowed wait.
    assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == CNT_W'(MEM_TIMEOUT - 1));

    // A cycle spent waiting is one where FETCH or MEM holds its state.
    assign waiting = (next_state == cur_state) &&
                     ((cur_state == S_FETCH) || (cur_state == S_MEM));

    assign state      = cur_state;
    assign trap_cause = trap_cause_q;

    // Classify the opcode and pick the immediate format it uses.
    always_comb begin
        is_lui    = (ins[6:0] == OPC_LUI);
        is_auipc  = (ins[6:0] == OPC_AUIPC);
        is_jal    = (ins[6:0] == OPC_JAL);
        is_jalr   = (ins[6:0] == OPC_JALR);
        is_branch = (ins[6:0] == OPC_BRANCH);
        is_load   = (ins[6:0] == OPC_LOAD);
        is_store  = (ins[6:0] == OPC_STORE);
        is_opimm  = (ins[6:0] == OPC_OPIMM);
        is_op     = (ins[6:0] == OPC_OP);
        is_legal  = is_lui | is_auipc | is_jal | is_jalr | is_branch |
                    is_load | is_store | is_opimm | is_op;
        dec_imm   = IMM_I;
        if (is_lui || is_auipc) begin
            dec_imm = IMM_U;
        end else if (is_jal) begin
            dec_imm = IMM_J;
        end else if (is_branch) begin
            dec_imm = IMM_B;
        end else if (is_store) begin
            dec_imm = IMM_S;
        end
    end

    // State, wait counter and latched trap cause; reset abandons everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state    <= S_BOOT;
            wait_cnt     <= '0;
            trap_cause_q <= 2'd0;
        end else begin
            cur_state <= next_state;
            if (waiting) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end else begin
                wait_cnt <= '0;
            end
            if ((next_state == S_HALT) && (cur_state != S_HALT)) begin
                trap_cause_q <= next_cause;
            end
        end
    end

    // Next-state selection, including the trap cause when heading to HALT.
    always_comb begin
        next_state = cur_state;
        next_cause = 2'd0;
        case (cur_state)
            S_BOOT: next_state = S_FETCH;
            S_FETCH: begin
                if (ins_ready) begin
                    next_state = S_DECODE;
                end else if (timeout_hit) begin
                    next_state = S_HALT;
                    next_cause = 2'd2;
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    next_state = S_EXEC;
                end else begin
                    next_state = S_HALT;
                    next_cause = 2'd1;
                end
            end
            S_EXEC: begin
                if (is_branch) begin
                    next_state = S_FETCH;
                end else if (is_load || is_store) begin
                    next_state = S_MEM;
                end else begin
                    next_state = S_WB;
                end
            end
            S_MEM: begin
                if (dmem_ready) begin
                    next_state = is_store ? S_FETCH : S_WB;
                end else if (timeout_hit) begin
                    next_state = S_HALT;
                    next_cause = 2'd3;
                end
            end
            S_WB:    next_state = S_FETCH;
            S_HALT:  next_state = S_HALT;
            default: next_state = S_BOOT;
        endcase
    end

    // Datapath controls decoded from the current state and instruction.
    always_comb begin
        ins_req   = 1'b0;
        ir_write  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        pc_write  = 1'b0;
        pc_src    = 1'b0;
        imm_type  = IMM_I;
        alu_src_a = 2'd0;
        alu_src_b = 1'b0;
        alu_ctl   = 2'd0;
        reg_write = 1'b0;
        wb_sel    = 2'd0;
        trap      = 1'b0;
        case (cur_state)
            S_FETCH: begin
                ins_req  = 1'b1;
                ir_write = ins_ready;
            end
            S_DECODE: imm_type = dec_imm;
            S_EXEC: begin
                imm_type = dec_imm;
                if (is_lui) begin
                    alu_src_a = 2'd2;
                end else if (is_auipc || is_jal || is_branch) begin
                    alu_src_a = 2'd1;
                end
                alu_src_b = ~is_op;
                if (is_op) begin
                    alu_ctl = 2'd1;
                end else if (is_opimm) begin
                    alu_ctl = 2'd2;
                end
                if (is_branch) begin
                    pc_write = 1'b1;
                    pc_src   = br_taken;
                end else if (is_jal || is_jalr) begin
                    pc_write = 1'b1;
                    pc_src   = 1'b1;
                end
            end
            S_MEM: begin
                imm_type = dec_imm;
                dmem_req = 1'b1;
                dmem_we  = is_store;
                pc_write = is_store & dmem_ready;
            end
            S_WB: begin
                reg_write = 1'b1;
                if (is_load) begin
                    wb_sel = 2'd1;
                end else if (is_jal || is_jalr) begin
                    wb_sel = 2'd2;
                end
                pc_write = ~(is_jal | is_jalr);
            end
            S_HALT:  trap = 1'b1;
            default: trap = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: builds the expected per-cycle
// output trace of each instruction from the sequencing rules and compares it
// against the design every cycle.
module tb_multicycle_control;

    localparam int TIMEOUT = 15;

    typedef struct packed {
        logic [2:0] state;
        logic       ins_req;
        logic       ir_write;
        logic       dmem_req;
        logic       dmem_we;
        logic       pc_write;
        logic       pc_src;
        logic [2:0] imm_type;
        logic [1:0] alu_src_a;
        logic       alu_src_b;
        logic [1:0] alu_ctl;
        logic       reg_write;
        logic [1:0] wb_sel;
        logic       trap;
        logic [1:0] trap_cause;
    } outs_t;

    typedef struct packed {
        outs_t exp;
        logic  ins_ready;
        logic  dmem_ready;
    } step_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] ins;
    logic        ins_ready;
    logic        dmem_ready;
    logic        br_taken;
    logic        ins_req, ir_write, dmem_req, dmem_we, pc_write, pc_src;
    logic [2:0]  imm_type;
    logic [1:0]  alu_src_a;
    logic        alu_src_b;
    logic [1:0]  alu_ctl;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        trap;
    logic [1:0]  trap_cause;
    logic [2:0]  state;

    int    vectors     = 0;
    int    miscompares = 0;
    step_t trace[$];

    multicycle_control #(.TYPE_W(3), .MEM_TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ins        (ins),
        .ins_ready  (ins_ready),
        .dmem_ready (dmem_ready),
        .br_taken   (br_taken),
        .ins_req    (ins_req),
        .ir_write   (ir_write),
        .dmem_req   (dmem_req),
        .dmem_we    (dmem_we),
        .pc_write   (pc_write),
        .pc_src     (pc_src),
        .imm_type   (imm_type),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_ctl    (alu_ctl),
        .reg_write  (reg_write),
        .wb_sel     (wb_sel),
        .trap       (trap),
        .trap_cause (trap_cause),
        .state      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic outs_t sample();
        outs_t o;
        o = '{state, ins_req, ir_write, dmem_req, dmem_we, pc_write, pc_src,
              imm_type, alu_src_a, alu_src_b, alu_ctl, reg_write, wb_sel,
              trap, trap_cause};
        return o;
    endfunction

    function automatic outs_t blank(input logic [2:0] st);
        outs_t o;
        o = '0;
        o.state = st;
        return o;
    endfunction

    task automatic check(input string tag, input outs_t act, input outs_t exp);
        vectors++;
        assert (act === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic push(input outs_t o, input logic ir, input logic dr);
        step_t s;
        s.exp = o;
        s.ins_ready = ir;
        s.dmem_ready = dr;
        trace.push_back(s);
    endtask

    task automatic push_halt(input logic [1:0] cause, input int n);
        outs_t o;
        o = blank(3'd6);
        o.trap = 1'b1;
        o.trap_cause = cause;
        for (int k = 0; k < n; k++) push(o, 1'b0, 1'b0);
    endtask

    // Reference model: expected cycle trace of one instruction, from FETCH
    // until the next FETCH (or a number of HALT cycles after a trap).
    task automatic build(input logic [31:0] i, input int di, input int dm,
                         input logic br, input int halt_n);
        logic [6:0] opc;
        logic       legal, is_br, is_jmp, is_ld, is_st;
        logic [2:0] imm;
        logic [1:0] sa, ctl, wsel;
        logic       sb;
        outs_t      o;
        opc = i[6:0];
        legal = 1'b1; is_br = 1'b0; is_jmp = 1'b0; is_ld = 1'b0; is_st = 1'b0;
        imm = 3'd0; sa = 2'd0; sb = 1'b1; ctl = 2'd0; wsel = 2'd0;
        case (opc)
            7'b0110111: begin imm = 3'd3; sa = 2'd2; end
            7'b0010111: begin imm = 3'd3; sa = 2'd1; end
            7'b1101111: begin imm = 3'd4; sa = 2'd1; is_jmp = 1'b1; wsel = 2'd2; end
            7'b1100111: begin imm = 3'd0; is_jmp = 1'b1; wsel = 2'd2; end
            7'b1100011: begin imm = 3'd2; sa = 2'd1; is_br = 1'b1; end
            7'b0000011: begin imm = 3'd0; is_ld = 1'b1; wsel = 2'd1; end
            7'b0100011: begin imm = 3'd1; is_st = 1'b1; end
            7'b0010011: begin imm = 3'd0; ctl = 2'd2; end
            7'b0110011: begin imm = 3'd0; sb = 1'b0; ctl = 2'd1; end
            default:    legal = 1'b0;
        endcase
        trace.delete();
        if (di >= TIMEOUT) begin
            o = blank(3'd1); o.ins_req = 1'b1;
            for (int k = 0; k < TIMEOUT; k++) push(o, 1'b0, 1'b0);
            push_halt(2'd2, halt_n);
            return;
        end
        for (int k = 0; k <= di; k++) begin
            o = blank(3'd1); o.ins_req = 1'b1; o.ir_write = (k == di);
            push(o, k == di, 1'b0);
        end
        o = blank(3'd2); o.imm_type = legal ? imm : 3'd0;
        push(o, 1'b0, 1'b0);
        if (!legal) begin
            push_halt(2'd1, halt_n);
            return;
        end
        o = blank(3'd3); o.imm_type = imm; o.alu_src_a = sa; o.alu_src_b = sb;
        o.alu_ctl = ctl;
        if (is_br) begin o.pc_write = 1'b1; o.pc_src = br; end
        if (is_jmp) begin o.pc_write = 1'b1; o.pc_src = 1'b1; end
        push(o, 1'b0, 1'b0);
        if (is_br) return;
        if (is_ld || is_st) begin
            o = blank(3'd4); o.imm_type = imm; o.dmem_req = 1'b1; o.dmem_we = is_st;
            if (dm >= TIMEOUT) begin
                for (int k = 0; k < TIMEOUT; k++) push(o, 1'b0, 1'b0);
                push_halt(2'd3, halt_n);
                return;
            end
            for (int k = 0; k <= dm; k++) begin
                o.pc_write = is_st && (k == dm);
                push(o, 1'b0, k == dm);
            end
            if (is_st) return;
        end
        o = blank(3'd5); o.reg_write = 1'b1; o.wb_sel = wsel; o.pc_write = !is_jmp;
        push(o, 1'b0, 1'b0);
    endtask

    // Drive the trace one cycle at a time; starts and ends just after a rising edge.
    task automatic applyStimulus(input string name, input int max_cycles);
        int n;
        n = (max_cycles < trace.size()) ? max_cycles : trace.size();
        for (int c = 0; c < n; c++) begin
            ins_ready  = trace[c].ins_ready;
            dmem_ready = trace[c].dmem_ready;
            @(negedge clk);
            check($sformatf("%s cyc%0d", name, c), sample(), trace[c].exp);
            @(posedge clk);
            #1;
        end
        ins_ready  = 1'b0;
        dmem_ready = 1'b0;
    endtask

    task automatic run(input string name, input logic [31:0] i, input int di,
                       input int dm, input logic br, input int halt_n);
        ins = i;
        br_taken = br;
        build(i, di, dm, br, halt_n);
        applyStimulus(name, 1000);
    endtask

    // Pulse reset, check the asynchronous drop, then the single BOOT cycle.
    task automatic do_reset();
        rst_n = 1'b0;
        ins_ready = 1'b0;
        dmem_ready = 1'b0;
        #1;
        check("reset async", sample(), blank(3'd0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("boot", sample(), blank(3'd0));
        @(posedge clk);
        #1;
    endtask

    logic [6:0] ops [9] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                            7'b1100011, 7'b0000011, 7'b0100011, 7'b0010011,
                            7'b0110011};

    initial begin
        logic [31:0] r;
        rst_n = 1'b1; ins = 32'h0000_0013; ins_ready = 1'b0;
        dmem_ready = 1'b0; br_taken = 1'b0;
        #2;
        do_reset();

        run("addi", 32'h0050_0093, 0, 0, 1'b0, 0);
        run("jalr", 32'h0000_80E7, 0, 0, 1'b0, 0);
        run("store0", 32'h0020_A023, 0, 0, 1'b0, 0);
        run("beq_t", 32'h0020_8463, 0, 0, 1'b1, 0);
        run("beq_n", 32'h0020_8463, 0, 0, 1'b0, 0);
        run("lui", 32'h1234_50B7, 0, 0, 1'b0, 0);
        run("jal", 32'h0080_00EF, 0, 0, 1'b0, 0);
        run("auipc", 32'h0000_1097, 1, 0, 1'b0, 0);
        run("add", 32'h0020_81B3, 2, 0, 1'b0, 0);
        run("load_w3", 32'h0000_A103, 0, 3, 1'b0, 0);
        run("store_w3", 32'h0020_A023, 0, 3, 1'b0, 0);
        run("fetch_w14", 32'h0050_0093, TIMEOUT - 1, 0, 1'b0, 0);
        run("load_w14", 32'h0000_A103, 0, TIMEOUT - 1, 1'b0, 0);

        for (int n = 0; n < 40; n++) begin
            r = $urandom();
            run($sformatf("rand%0d", n), {r[31:7], ops[$urandom_range(0, 8)]},
                $urandom_range(0, 4), $urandom_range(0, 4), r[0], 0);
        end

        run("imem_timeout", 32'h0050_0093, TIMEOUT, 0, 1'b0, 4);
        do_reset();
        run("dmem_timeout", 32'h0000_A103, 0, TIMEOUT, 1'b0, 4);
        do_reset();
        run("illegal", 32'hAF2B_5CFB, 0, 0, 1'b0, 20);
        do_reset();

        // Reset in the middle of a load that is still waiting on memory.
        ins = 32'h0000_A103;
        br_taken = 1'b0;
        build(ins, 0, 6, 1'b0, 0);
        applyStimulus("mid_mem", 5);
        #1;
        check("mid_mem held", sample(), trace[5].exp);
        do_reset();
        run("after_reset", 32'h0050_0093, 0, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
